// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and address helper for the VGA text writer.
// Optional feature macro: VGA_TEXT_SCROLL_EN adds the scroll states to the enum.
package vga_text_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_TILES = 2400;
  localparam logic [12:0] TEXT_BASE = 13'h1000;

  localparam logic [6:0]  COL_LAST    = 7'(TEXT_COLS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(TEXT_ROWS - 1);
  localparam logic [11:0] TILE_ROW    = 12'(TEXT_COLS);
  localparam logic [11:0] TILE_END    = 12'(TEXT_TILES);
  localparam logic [11:0] TILE_LAST   = 12'(TEXT_TILES - 1);
  localparam logic [11:0] SCROLL_LAST = 12'(TEXT_TILES - TEXT_COLS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLEAR
`ifdef VGA_TEXT_SCROLL_EN
    , SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR
`endif
  } state_t;

  // Text buffer address of a tile; tiles stop at 2399 so this never passes 13'h195F.
  function automatic logic [12:0] tile_addr(input logic [11:0] tile);
    return TEXT_BASE + {1'b0, tile};
  endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Column/row cursor for the 80x30 text screen, with tile index output.
// wrap flags that the cursor is on the last row, so a line break would leave the screen.
module vga_text_cursor
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        newline,
  input  logic        carriage,
  input  logic        home,
  input  logic        back,
  input  logic        set_row_last,
  output logic [6:0]  col,
  output logic [4:0]  row,
  output logic        wrap,
  output logic [11:0] tile
);

  assign wrap = (row == ROW_LAST);

  // row*80 + col as shift-and-add, no multiplier
  assign tile = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};

  // Cursor update; set_row_last overrides a simultaneous advance/newline when scrolling
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (set_row_last) begin
      col <= '0;
      row <= ROW_LAST;
    end else if (back) begin
      col <= col - 7'd1;
    end else if (newline) begin
      col <= '0;
      row <= wrap ? 5'd0 : row + 5'd1;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= wrap ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 7'd1;
      end
    end else if (carriage) begin
      col <= '0;
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Character stream to single-beat text-buffer writes for vga_top.
// Optional feature macro: VGA_TEXT_SCROLL_EN scrolls the screen up one row on
// row overflow instead of wrapping the cursor to row 0.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 13,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic                          axil_wready_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i,
  output logic [6:0]                    cursor_col_o,
  output logic [4:0]                    cursor_row_o,
  output logic                          busy_o
);

  localparam int AW = C_AXI_ADDR_WIDTH;

  state_t         state, state_next;
  logic [11:0]    idx, idx_next;
  logic           wready_n;
  logic [AW-1:0]  waddr_n;
  logic [7:0]     wchar, wchar_n;
  logic           advance, newline, carriage, home, back, set_row_last;
  logic [6:0]     col;
  logic [4:0]     row;
  logic           wrap;
  logic [11:0]    tile;
  logic           accept;
  logic           unused_in;

  assign accept       = s_valid_i & s_ready_o;
  assign cursor_col_o = col;
  assign cursor_row_o = row;
  assign axil_wdata_o = {{(C_AXI_DATA_WIDTH-8){1'b0}}, wchar};
  assign axil_wstrb_o = {{(C_AXI_DATA_WIDTH/8-1){1'b0}}, axil_wready_o};
  assign unused_in    = ^{axil_rdata_i, wrap};

  vga_text_cursor u_cursor (
    .clk          (clk_i),
    .rst          (rst_i),
    .advance      (advance),
    .newline      (newline),
    .carriage     (carriage),
    .home         (home),
    .back         (back),
    .set_row_last (set_row_last),
    .col          (col),
    .row          (row),
    .wrap         (wrap),
    .tile         (tile)
  );

`ifdef VGA_TEXT_SCROLL_EN
  logic           pend, pend_next;
  logic           rreq_n;
  logic [AW-1:0]  raddr_n;
`else
  assign axil_rreq_o  = 1'b0;
  assign axil_raddr_o = '0;
`endif

  // Next-state decode; every output is computed here and registered below
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    wready_n     = 1'b0;
    waddr_n      = axil_waddr_o;
    wchar_n      = wchar;
    advance      = 1'b0;
    newline      = 1'b0;
    carriage     = 1'b0;
    home         = 1'b0;
    back         = 1'b0;
    set_row_last = 1'b0;
`ifdef VGA_TEXT_SCROLL_EN
    pend_next    = pend;
    rreq_n       = 1'b0;
    raddr_n      = axil_raddr_o;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_data_i >= CH_SPACE && s_data_i <= CH_TILDE) begin
            wready_n   = 1'b1;
            waddr_n    = AW'(tile_addr(tile));
            wchar_n    = s_data_i;
            advance    = 1'b1;
            state_next = WRITE;
`ifdef VGA_TEXT_SCROLL_EN
            // Last tile of the screen: the write goes out first, the scroll follows
            if (wrap && col == COL_LAST) begin
              set_row_last = 1'b1;
              pend_next    = 1'b1;
            end
`endif
          end else if (s_data_i == CH_BS) begin
            if (col != 7'd0) begin
              back       = 1'b1;
              wready_n   = 1'b1;
              waddr_n    = AW'(tile_addr(tile - 12'd1));
              wchar_n    = CH_SPACE;
              state_next = WRITE;
            end
          end else if (s_data_i == CH_CR) begin
            carriage = 1'b1;
          end else if (s_data_i == CH_LF) begin
            newline = 1'b1;
`ifdef VGA_TEXT_SCROLL_EN
            if (wrap) begin
              set_row_last = 1'b1;
              state_next   = SCROLL_RD;
              idx_next     = '0;
              rreq_n       = 1'b1;
              raddr_n      = AW'(tile_addr(TILE_ROW));
            end
`endif
          end else if (s_data_i == CH_FF) begin
            wready_n   = 1'b1;
            waddr_n    = AW'(tile_addr(12'd0));
            wchar_n    = CH_SPACE;
            idx_next   = 12'd1;
            state_next = CLEAR;
          end
        end
      end
      WRITE: begin
        state_next = IDLE;
`ifdef VGA_TEXT_SCROLL_EN
        if (pend) begin
          pend_next  = 1'b0;
          state_next = SCROLL_RD;
          idx_next   = '0;
          rreq_n     = 1'b1;
          raddr_n    = AW'(tile_addr(TILE_ROW));
        end
`endif
      end
      CLEAR: begin
        if (idx == TILE_END) begin
          home       = 1'b1;
          state_next = IDLE;
        end else begin
          wready_n = 1'b1;
          waddr_n  = AW'(tile_addr(idx));
          wchar_n  = CH_SPACE;
          idx_next = idx + 12'd1;
        end
      end
`ifdef VGA_TEXT_SCROLL_EN
      SCROLL_RD: begin
        state_next = SCROLL_WR;
      end
      SCROLL_WR: begin
        // Read data for tile+80 arrives this cycle; copy it down one row
        wready_n = 1'b1;
        waddr_n  = AW'(tile_addr(idx));
        wchar_n  = axil_rdata_i[7:0];
        idx_next = idx + 12'd1;
        if (idx == SCROLL_LAST) begin
          state_next = SCROLL_CLR;
        end else begin
          state_next = SCROLL_RD;
          rreq_n     = 1'b1;
          raddr_n    = AW'(tile_addr(idx + TILE_ROW + 12'd1));
        end
      end
      SCROLL_CLR: begin
        wready_n = 1'b1;
        waddr_n  = AW'(tile_addr(idx));
        wchar_n  = CH_SPACE;
        if (idx == TILE_LAST) begin
          state_next = IDLE;
        end else begin
          idx_next = idx + 12'd1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and sequencing counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
`ifdef VGA_TEXT_SCROLL_EN
      pend  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      idx   <= idx_next;
`ifdef VGA_TEXT_SCROLL_EN
      pend  <= pend_next;
`endif
    end
  end

  // Registered outputs; reset clears everything so an aborted sequence leaves no strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      axil_wready_o <= 1'b0;
      axil_waddr_o  <= '0;
      wchar         <= '0;
      s_ready_o     <= 1'b0;
      busy_o        <= 1'b0;
`ifdef VGA_TEXT_SCROLL_EN
      axil_rreq_o   <= 1'b0;
      axil_raddr_o  <= '0;
`endif
    end else begin
      axil_wready_o <= wready_n;
      axil_waddr_o  <= waddr_n;
      wchar         <= wchar_n;
      s_ready_o     <= (state_next == IDLE);
      busy_o        <= (state_next != IDLE);
`ifdef VGA_TEXT_SCROLL_EN
      axil_rreq_o   <= rreq_n;
      axil_raddr_o  <= raddr_n;
`endif
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer with a small text-buffer model.
// Scroll scenarios are compiled only when VGA_TEXT_SCROLL_EN is defined.
`timescale 1ns/1ps
module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [12:0] waddr;
  logic        wready;
  logic        rreq;
  logic [12:0] raddr;
  logic [31:0] rdata = 32'h0;
  logic [6:0]  ccol;
  logic [4:0]  crow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:2399];

  always #5 clk = ~clk;

  vga_text_writer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .axil_wdata_o  (wdata),
    .axil_wstrb_o  (wstrb),
    .axil_waddr_o  (waddr),
    .axil_wready_o (wready),
    .axil_rreq_o   (rreq),
    .axil_raddr_o  (raddr),
    .axil_rdata_i  (rdata),
    .cursor_col_o  (ccol),
    .cursor_row_o  (crow),
    .busy_o        (busy)
  );

  // Text buffer model: writes on strobe, read data one cycle after rreq
  always @(posedge clk) begin
    int wa;
    int ra;
    wa = int'(waddr) - 4096;
    ra = int'(raddr) - 4096;
    if (wready && wa >= 0 && wa < 2400) mem[wa] <= wdata[7:0];
    if (rreq) rdata <= (ra >= 0 && ra < 2400) ? {24'h0, mem[ra]} : 32'hDEAD;
  end

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Waits for s_ready (bounded), presents one byte for one cycle; returns in cycle N+1
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data = c;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_sready: got %b required 0", s_ready); end
    checks++;
    if ({wready, wstrb, waddr, wdata, busy} !== '0) begin
      errors++; $display("FAIL reset_bus: wready=%b wstrb=%h waddr=%h wdata=%h busy=%b required all 0", wready, wstrb, waddr, wdata, busy);
    end
    checks++;
    if ({ccol, crow} !== 12'h0) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", ccol, crow); end
    checks++;
    if ({rreq, raddr} !== 14'h0) begin errors++; $display("FAIL reset_read: rreq=%b raddr=%h required 0", rreq, raddr); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: s_ready=%b busy=%b required 1/0", s_ready, busy);
    end
  endtask

  task automatic test_char_a();
    do_reset();
    send(8'h41);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h1000 || wdata !== 32'h41 || wstrb !== 4'b0001) begin
      errors++; $display("FAIL char_a_write: wready=%b waddr=%h wdata=%h wstrb=%b required 1/1000/00000041/0001", wready, waddr, wdata, wstrb);
    end
    checks++;
    if (ccol !== 7'd1 || crow !== 5'd0) begin errors++; $display("FAIL char_a_cursor: got (%0d,%0d) required (1,0)", ccol, crow); end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL char_a_busy: s_ready=%b busy=%b required 0/1", s_ready, busy); end
    @(posedge clk);
    #1;
    checks++;
    if (wready !== 1'b0 || wstrb !== 4'b0000 || s_ready !== 1'b1) begin
      errors++; $display("FAIL char_a_after: wready=%b wstrb=%b s_ready=%b required 0/0000/1", wready, wstrb, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 81; k++) begin
      send(8'h42);
      checks++;
      if (wready !== 1'b1 || waddr !== 13'(13'h1000 + k) || wdata !== 32'h42) begin
        errors++; $display("FAIL b2b_write[%0d]: wready=%b waddr=%h wdata=%h required 1/%h/00000042", k, wready, waddr, wdata, 13'(13'h1000 + k));
      end
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n1[%0d]: got %b required 0", k, s_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (s_ready !== 1'b1 || wready !== 1'b0) begin
        errors++; $display("FAIL b2b_ready_n2[%0d]: s_ready=%b wready=%b required 1/0", k, s_ready, wready);
      end
    end
    checks++;
    if (ccol !== 7'd1 || crow !== 5'd1) begin errors++; $display("FAIL b2b_cursor: got (%0d,%0d) required (1,1)", ccol, crow); end
  endtask

  task automatic test_backspace();
    do_reset();
    send(8'h58);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h1000 || wdata !== 32'h58) begin
      errors++; $display("FAIL bs_x: wready=%b waddr=%h wdata=%h required 1/1000/00000058", wready, waddr, wdata);
    end
    send(8'h08);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h1000 || wdata !== 32'h20) begin
      errors++; $display("FAIL bs_first: wready=%b waddr=%h wdata=%h required 1/1000/00000020", wready, waddr, wdata);
    end
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd0) begin errors++; $display("FAIL bs_cursor1: got (%0d,%0d) required (0,0)", ccol, crow); end
    send(8'h08);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd0 || crow !== 5'd0) begin
      errors++; $display("FAIL bs_second: wready=%b s_ready=%b cursor=(%0d,%0d) required 0/1/(0,0)", wready, s_ready, ccol, crow);
    end
    send(8'h59);
    send(8'h5A);
    send(8'h08);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h1001 || wdata !== 32'h20 || ccol !== 7'd1) begin
      errors++; $display("FAIL bs_mid: wready=%b waddr=%h wdata=%h col=%0d required 1/1001/00000020/1", wready, waddr, wdata, ccol);
    end
  endtask

  task automatic test_clear();
    int bad;
    int bad_i;
    do_reset();
    send(8'h41);
    send(8'h0C);
    bad = 0;
    bad_i = -1;
    for (int i = 0; i < 2400; i++) begin
      if ((wready !== 1'b1 || waddr !== 13'(13'h1000 + i) || wdata !== 32'h20 || s_ready !== 1'b0) && bad == 0) begin
        bad = 1;
        bad_i = i;
        $display("FAIL clear_strobe[%0d]: wready=%b waddr=%h wdata=%h s_ready=%b required 1/%h/00000020/0", i, wready, waddr, wdata, s_ready, 13'(13'h1000 + i));
      end
      if (i != 2399) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(posedge clk);
    #1;
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_end: wready=%b s_ready=%b busy=%b required 0/1/0 at N+2401 (first bad %0d)", wready, s_ready, busy, bad_i);
    end
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd0) begin errors++; $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", ccol, crow); end
    checks++;
    if (mem[0] !== 8'h20 || mem[2399] !== 8'h20) begin
      errors++; $display("FAIL clear_mem: tile0=%h tile2399=%h required 20/20", mem[0], mem[2399]);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    send(8'h0C);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wready, wstrb, waddr, wdata, busy, s_ready, ccol, crow, rreq, raddr} !== '0) begin
      errors++; $display("FAIL abort_clear: wready=%b waddr=%h wdata=%h busy=%b s_ready=%b cursor=(%0d,%0d) required all 0", wready, waddr, wdata, busy, s_ready, ccol, crow);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h5A);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h1000 || wdata !== 32'h5A) begin
      errors++; $display("FAIL abort_clear_next: wready=%b waddr=%h wdata=%h required 1/1000/0000005A", wready, waddr, wdata);
    end
  endtask

  task automatic test_codes();
    do_reset();
    send(8'h41);
    send(8'h41);
    send(8'h7F);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd2 || crow !== 5'd0) begin
      errors++; $display("FAIL drop_7f: wready=%b s_ready=%b cursor=(%0d,%0d) required 0/1/(2,0)", wready, s_ready, ccol, crow);
    end
    send(8'h01);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd2) begin
      errors++; $display("FAIL drop_01: wready=%b s_ready=%b col=%0d required 0/1/2", wready, s_ready, ccol);
    end
    send(8'h0A);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd0 || crow !== 5'd1) begin
      errors++; $display("FAIL lf_basic: wready=%b s_ready=%b cursor=(%0d,%0d) required 0/1/(0,1)", wready, s_ready, ccol, crow);
    end
    send(8'h41);
    send(8'h0D);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd0 || crow !== 5'd1) begin
      errors++; $display("FAIL cr_basic: wready=%b s_ready=%b cursor=(%0d,%0d) required 0/1/(0,1)", wready, s_ready, ccol, crow);
    end
  endtask

`ifndef VGA_TEXT_SCROLL_EN
  task automatic test_row_wrap();
    do_reset();
    for (int k = 0; k < 29; k++) send(8'h0A);
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd29) begin errors++; $display("FAIL wrap_row29: got (%0d,%0d) required (0,29)", ccol, crow); end
    for (int k = 0; k < 80; k++) send(8'h43);
    checks++;
    if (wready !== 1'b1 || waddr !== 13'h195F || wdata !== 32'h43) begin
      errors++; $display("FAIL wrap_last_tile: wready=%b waddr=%h wdata=%h required 1/195F/00000043", wready, waddr, wdata);
    end
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd0) begin errors++; $display("FAIL wrap_print_cursor: got (%0d,%0d) required (0,0)", ccol, crow); end
    for (int k = 0; k < 29; k++) send(8'h0A);
    send(8'h0A);
    checks++;
    if (wready !== 1'b0 || s_ready !== 1'b1 || ccol !== 7'd0 || crow !== 5'd0) begin
      errors++; $display("FAIL wrap_lf: wready=%b s_ready=%b cursor=(%0d,%0d) required 0/1/(0,0)", wready, s_ready, ccol, crow);
    end
  endtask
`endif

`ifdef VGA_TEXT_SCROLL_EN
  task automatic test_scroll();
    int cnt;
    do_reset();
    for (int i = 0; i < 2400; i++) mem[i] = 8'h00;
    send(8'h0A);
    for (int k = 0; k < 80; k++) send(8'h52);
    for (int k = 0; k < 27; k++) send(8'h0A);
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd29) begin errors++; $display("FAIL scroll_pre: got (%0d,%0d) required (0,29)", ccol, crow); end
    send(8'h0A);
    cnt = 0;
    while (busy === 1'b1 && cnt < 6000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (cnt != 4720) begin errors++; $display("FAIL scroll_busy: got %0d cycles required 4720", cnt); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ccol !== 7'd0 || crow !== 5'd29) begin errors++; $display("FAIL scroll_cursor: got (%0d,%0d) required (0,29)", ccol, crow); end
    checks++;
    if (mem[0] !== 8'h52 || mem[79] !== 8'h52 || mem[80] !== 8'h00) begin
      errors++; $display("FAIL scroll_row0: t0=%h t79=%h t80=%h required 52/52/00", mem[0], mem[79], mem[80]);
    end
    checks++;
    if (mem[2320] !== 8'h20 || mem[2399] !== 8'h20) begin
      errors++; $display("FAIL scroll_row29: t2320=%h t2399=%h required 20/20", mem[2320], mem[2399]);
    end
    send(8'h0A);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wready, wstrb, waddr, wdata, busy, s_ready, ccol, crow, rreq, raddr} !== '0) begin
      errors++; $display("FAIL abort_scroll: wready=%b waddr=%h rreq=%b raddr=%h busy=%b cursor=(%0d,%0d) required all 0", wready, waddr, rreq, raddr, busy, ccol, crow);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2400; i++) mem[i] = 8'h00;
    test_reset();
    test_char_a();
    test_back_to_back();
    test_backspace();
    test_codes();
    test_clear();
    test_reset_mid_clear();
`ifndef VGA_TEXT_SCROLL_EN
    test_row_wrap();
`else
    test_scroll();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Bus-initiator that turns a byte stream of ASCII characters into single-beat writes on the vga_top register/buffer port. It sits between a character source (UART receiver, CPU FIFO) and vga_top. It keeps an 80x30 cursor, interprets a small set of control codes, and drives the text buffer at base 13'h1000 (tile = row*80+col, 0..2399). It never touches the ROM (13'h0000) or colour registers (13'h0800).

## Interface
- C_AXI_ADDR_WIDTH, 13, address width of the vga_top port
- C_AXI_DATA_WIDTH, 32, data width of the vga_top port
- clk_i  in  1  system clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- s_data_i  in  8  input character
- s_valid_i  in  1  character valid
- s_ready_o  out  1  character accepted when s_valid_i & s_ready_o
- axil_wdata_o  out  C_AXI_DATA_WIDTH  {24'b0, char}
- axil_wstrb_o  out  C_AXI_DATA_WIDTH/8  4'b0001 during a write, 4'b0000 otherwise
- axil_waddr_o  out  C_AXI_ADDR_WIDTH  13'h1000 + tile
- axil_wready_o  out  1  one-cycle write strobe; vga_top accepts every strobed cycle, no backpressure
- axil_rreq_o  out  1  read request (used only with scroll enabled)
- axil_raddr_o  out  C_AXI_ADDR_WIDTH  read address
- axil_rdata_i  in  C_AXI_DATA_WIDTH  read data, valid the cycle after axil_rreq_o
- cursor_col_o  out  7  current column 0..79
- cursor_row_o  out  5  current row 0..29
- busy_o  out  1  high in any state other than IDLE

## Operation
- Every output is registered. Reset values are all 0, cursor is (0,0), and s_ready_o is 0 during the reset cycle and 1 in IDLE afterwards.
- States are IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR and SCROLL_CLR. s_ready_o is high only in IDLE.
- Printable characters (0x20..0x7E): IDLE goes to WRITE. The block writes the character at the cursor, then advances the cursor.
  - When col==79, the cursor moves to col 0 and row+1.
  - When the row would leave row 29, the cursor either wraps or scrolls (see Configuration).
- 0x0D (CR): col is set to 0. No write.
- 0x0A (LF): col is set to 0 and the row advances using the same row-overflow rule. No write.
- 0x08 (BS): if col>0, col decrements and 0x20 is written at the new position. At col 0 the character is a no-op.
- 0x0C (FF): IDLE goes to CLEAR. 0x20 is written to tiles 0..2399 in ascending order, one per cycle, and the cursor is then set to (0,0).
- All other codes, including bytes ≥0x7F, are accepted and dropped with no write and no cursor change.
- Tile arithmetic:
  - 12-bit tile = row*80 + col, computed as (row<<6)+(row<<4)+col with no multiplier.
  - The address is a 13-bit sum with base 13'h1000. It never exceeds 13'h195F.
- Reset in any state aborts immediately. Tiles already written stay written, and the next write after reset starts at tile 0.

## Timing
- Printable or BS:
  - Accept in cycle N.
  - axil_wready_o is high in cycle N+1 only, with the address taken from the pre-advance cursor.
  - The cursor outputs update in N+1.
  - s_ready_o returns in N+2. Maximum throughput is 1 character per 2 cycles.
- CR, LF, dropped codes: the cursor updates in N+1 and s_ready_o returns in N+1.
- FF:
  - axil_wready_o is high continuously for cycles N+1..N+2400.
  - s_ready_o returns in N+2401 with the cursor at (0,0).
- Scroll, per tile:
  - SCROLL_RD pulses axil_rreq_o with raddr set to tile+80.
  - The next cycle, SCROLL_WR writes axil_rdata_i[7:0] to that tile.
  - This covers tiles 0..2319, then SCROLL_CLR writes 0x20 to tiles 2320..2399.
  - The total is 2*2320+80 = 4720 busy cycles after the triggering write or LF. The cursor ends at (0,29).
- The triggering printable character is written before the scroll starts, so its write and the scroll are never in the same cycle.

## Configuration
- VGA_TEXT_SCROLL_EN defined: on row overflow the block enters SCROLL_RD as described above, and axil_rreq_o/axil_raddr_o are driven.
- Not defined: row overflow wraps to row 0 with no extra cycles. The SCROLL_* states are absent, and axil_rreq_o and axil_raddr_o are tied to 0.

## Structure
- The package vga_text_pkg holds:
  - TEXT_COLS=80, TEXT_ROWS=30, TEXT_TILES=2400, TEXT_BASE=13'h1000;
  - the character constants CH_BS, CH_LF, CH_FF, CH_CR, CH_SPACE;
  - the state enum.
- Sub-module vga_text_cursor holds the col/row counters. Its controls are advance, newline, home, back and set_row_last, and it produces a wrap flag and the tile index.

## Test plan
- 'A' (0x41) after reset → one strobe with waddr 13'h1000, wdata 32'h41, wstrb 4'b0001; cursor becomes (1,0).
- 81 × 'B' → the 81st write goes to 13'h1050 and the cursor becomes (1,1). Check s_ready_o spacing of 2 cycles.
- Cursor at (0,29), send LF without the macro → cursor (0,0), no strobe.
- 0x0C → exactly 2400 consecutive strobes over 13'h1000..13'h195F, all wdata 32'h20; s_ready_o returns at N+2401.
- 'X', then BS, then BS → writes 0x58@13'h1000 and 0x20@13'h1000; the second BS produces no strobe; cursor ends at (0,0).
- With VGA_TEXT_SCROLL_EN, and a bench model of the buffer that returns rdata one cycle after rreq: fill row 1 with 'R', move to row 29, send LF → row 0 reads back 'R', row 29 is all 0x20, busy_o is high for 4720 cycles. Also assert rst_i mid-scroll → all outputs 0 on the next cycle.
